// File: rtl/pipe_hazard_scoreboard.sv
// Decode-stage RAW hazard scoreboard: tracks in-flight destination writes in a
// LAT-deep shift pipe, stalls dependent readers, and handles flush and HLT drain.
module pipe_hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int LAT    = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr,
    input  logic              id_halt,
    input  logic              flush,
    output logic              id_stall,
    output logic              halted,
    output logic              drained,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  issue_cnt
);

    logic [LAT-1:0]    vld_q, vld_d;
    logic [REG_AW-1:0] rd_q [LAT];
    logic [REG_AW-1:0] rd_d [LAT];
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic              hazard;
    logic              issue;
    logic              load0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Register 0 is excluded on the read side; entries never hold it either.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            if (vld_q[i] && id_rs_used && (id_rs != '0) && (rd_q[i] == id_rs)) hazard = 1'b1;
            if (vld_q[i] && id_rt_used && (id_rt != '0) && (rd_q[i] == id_rt)) hazard = 1'b1;
        end
    end

    assign id_stall = id_valid & (hazard | halted_q);
    assign issue    = id_valid & ~id_stall;
    assign load0    = issue & id_wr & ~id_halt & (id_rd != '0);

    // Flush kills every older entry but keeps the one issuing this cycle.
    always_comb begin
        vld_d = '0;
        for (int i = 0; i < LAT; i++) rd_d[i] = '0;
        vld_d[0] = load0;
        rd_d[0]  = load0 ? id_rd : '0;
        for (int i = 1; i < LAT; i++) begin
            if (!flush) begin
                vld_d[i] = vld_q[i-1];
                rd_d[i]  = rd_q[i-1];
            end
        end
        halted_d    = halted_q | (issue & id_halt);
        stall_cnt_d = sat_inc(stall_cnt_q, id_valid & hazard & ~halted_q);
        issue_cnt_d = sat_inc(issue_cnt_q, issue);
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            vld_q       <= vld_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    // Register indices are qualified by vld_q, so they need no reset.
    always_ff @(posedge clk1) begin
        for (int i = 0; i < LAT; i++) rd_q[i] <= rd_d[i];
    end

    assign halted    = halted_q;
    assign drained   = halted_q & ~|vld_q;
    assign stall_cnt = stall_cnt_q;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for pipe_hazard_scoreboard: directed table, reset/saturation sequences,
// and random traffic checked against a per-register busy-until reference model.
module tb_pipe_hazard_scoreboard;

    localparam int REG_AW = 5;
    localparam int LAT    = 3;
    localparam int NREG   = 1 << REG_AW;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        id_rs_used = 1'b0, id_rt_used = 1'b0;
    logic        id_wr = 1'b0, id_halt = 1'b0, flush = 1'b0;
    logic        id_stall, halted, drained;
    logic [15:0] stall_cnt, issue_cnt;
    logic        s_stall, s_halted, s_drained;
    logic [3:0]  s_stall_cnt, s_issue_cnt;

    pipe_hazard_scoreboard #(.REG_AW(REG_AW), .LAT(LAT), .CNT_W(16)) dut (
        .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr(id_wr),
        .id_halt(id_halt), .flush(flush), .id_stall(id_stall), .halted(halted),
        .drained(drained), .stall_cnt(stall_cnt), .issue_cnt(issue_cnt));

    pipe_hazard_scoreboard #(.REG_AW(REG_AW), .LAT(LAT), .CNT_W(4)) dut_small (
        .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr(id_wr),
        .id_halt(id_halt), .flush(flush), .id_stall(s_stall), .halted(s_halted),
        .drained(s_drained), .stall_cnt(s_stall_cnt), .issue_cnt(s_issue_cnt));

    always #5 clk1 = ~clk1;

    typedef struct {
        bit v; bit [4:0] rs; bit rsu; bit [4:0] rt; bit rtu; bit [4:0] rd;
        bit wr; bit hlt; bit fl;
        bit e_st; bit e_h; bit e_d; int e_sc; int e_ic;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a register is busy through the cycle its write completes.
    int cyc = 0;
    int busy_until [NREG];
    bit m_halted;
    int m_sc, m_ic;

    function automatic vec_t mk(bit v, int rs, bit rsu, int rt, bit rtu, int rd, bit wr,
                                bit hlt, bit fl, bit st, bit h, bit d, int sc, int ic);
        vec_t r;
        r.v = v; r.rs = 5'(rs); r.rsu = rsu; r.rt = 5'(rt); r.rtu = rtu; r.rd = 5'(rd);
        r.wr = wr; r.hlt = hlt; r.fl = fl; r.e_st = st; r.e_h = h; r.e_d = d;
        r.e_sc = sc; r.e_ic = ic;
        return r;
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < NREG; r++) busy_until[r] = -1;
        m_halted = 0; m_sc = 0; m_ic = 0;
    endfunction

    function automatic bit m_hazard(vec_t v);
        bit h = 0;
        if (v.rsu && v.rs != 0 && busy_until[v.rs] >= cyc) h = 1;
        if (v.rtu && v.rt != 0 && busy_until[v.rt] >= cyc) h = 1;
        return h;
    endfunction

    function automatic bit m_any_busy();
        bit b = 0;
        for (int r = 0; r < NREG; r++) if (busy_until[r] >= cyc) b = 1;
        return b;
    endfunction

    function automatic void model_edge(vec_t v);
        bit haz = m_hazard(v);
        bit iss = v.v && !haz && !m_halted;
        if (v.v && haz && !m_halted) m_sc++;
        if (iss) m_ic++;
        if (v.fl) for (int r = 0; r < NREG; r++) busy_until[r] = -1;
        if (iss && v.wr && !v.hlt && v.rd != 0) busy_until[v.rd] = cyc + LAT;
        if (iss && v.hlt) m_halted = 1;
        cyc++;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        id_valid = v.v; id_rs = v.rs; id_rs_used = v.rsu; id_rt = v.rt; id_rt_used = v.rtu;
        id_rd = v.rd; id_wr = v.wr; id_halt = v.hlt; flush = v.fl;
    endtask

    // Drive just after a rising edge, check on the falling edge, advance the model on the next rising edge.
    task automatic step(vec_t v, bit use_tab);
        bit haz, st;
        drive(v);
        @(negedge clk1);
        haz = m_hazard(v);
        st  = v.v && (haz || m_halted);
        if (use_tab) begin
            chk("tab_stall", id_stall, v.e_st);
            chk("tab_halted", halted, v.e_h);
            chk("tab_drained", drained, v.e_d);
            chk("tab_stall_cnt", stall_cnt, v.e_sc);
            chk("tab_issue_cnt", issue_cnt, v.e_ic);
        end else begin
            chk("mdl_stall", id_stall, st);
            chk("mdl_halted", halted, m_halted);
            chk("mdl_drained", drained, m_halted && !m_any_busy());
            chk("mdl_stall_cnt", stall_cnt, sat(m_sc, 65535));
            chk("mdl_issue_cnt", issue_cnt, sat(m_ic, 65535));
        end
        chk("small_stall", s_stall, st);
        chk("small_stall_cnt", s_stall_cnt, sat(m_sc, 15));
        chk("small_issue_cnt", s_issue_cnt, sat(m_ic, 15));
        @(posedge clk1);
        model_edge(v);
        #1;
    endtask

    task automatic do_reset();
        drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
        rst_n = 1'b0;
        model_reset();
        @(posedge clk1);
        @(negedge clk1);
        rst_n = 1'b1;
        @(posedge clk1);
        #1;
    endtask

    vec_t tab [18];
    vec_t rv;
    vec_t idle;

    initial begin
        idle = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
        // Dependent stall, register 0, flush release, halt/drain.
        tab[0]  = mk(1,0,0,0,0,1,1,0,0, 0,0,0,0,0);
        tab[1]  = mk(1,1,1,0,0,2,1,0,0, 1,0,0,0,1);
        tab[2]  = mk(1,1,1,0,0,2,1,0,0, 1,0,0,1,1);
        tab[3]  = mk(1,1,1,0,0,2,1,0,0, 1,0,0,2,1);
        tab[4]  = mk(1,1,1,0,0,2,1,0,0, 0,0,0,3,1);
        tab[5]  = mk(1,2,0,0,0,0,1,0,0, 0,0,0,3,2);
        tab[6]  = mk(1,0,1,0,1,0,0,0,0, 0,0,0,3,3);
        tab[7]  = mk(0,0,0,0,0,0,0,0,0, 0,0,0,3,4);
        tab[8]  = mk(1,0,0,0,0,5,1,0,0, 0,0,0,3,4);
        tab[9]  = mk(1,5,1,0,0,0,0,0,1, 1,0,0,3,5);
        tab[10] = mk(1,5,1,0,0,0,0,0,0, 0,0,0,4,5);
        tab[11] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,4,6);
        tab[12] = mk(1,0,0,0,0,3,1,0,0, 0,0,0,4,6);
        tab[13] = mk(1,0,0,0,0,0,0,1,0, 0,0,0,4,7);
        tab[14] = mk(1,3,1,0,0,0,0,0,0, 1,1,0,4,8);
        tab[15] = mk(1,3,1,0,0,0,0,0,0, 1,1,0,4,8);
        tab[16] = mk(0,0,0,0,0,0,0,0,0, 0,1,1,4,8);
        tab[17] = mk(1,0,0,0,0,7,1,0,0, 1,1,1,4,8);

        model_reset();
        #1;
        chk("rst_halted", halted, 0);
        chk("rst_drained", drained, 0);
        chk("rst_issue_cnt", issue_cnt, 0);
        do_reset();
        for (int i = 0; i < 18; i++) step(tab[i], 1'b1);

        // Saturation of the narrow counter on back-to-back independent issues.
        do_reset();
        for (int i = 0; i < 20; i++)
            step(mk(1,0,0,0,0,$urandom_range(0,31),1,0,0, 0,0,0,0,0), 1'b0);
        chk("sat_small_issue", s_issue_cnt, 15);
        chk("wide_issue", issue_cnt, 20);

        // Asynchronous reset with two live entries and halted set.
        do_reset();
        step(mk(1,0,0,0,0,1,1,0,0, 0,0,0,0,0), 1'b0);
        step(mk(1,0,0,0,0,2,1,0,0, 0,0,0,0,0), 1'b0);
        step(mk(1,0,0,0,0,0,0,1,0, 0,0,0,0,0), 1'b0);
        chk("pre_rst_halted", halted, 1);
        chk("pre_rst_drained", drained, 0);
        drive(mk(1,1,1,2,1,4,1,0,0, 0,0,0,0,0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", id_stall, 0);
        chk("arst_halted", halted, 0);
        chk("arst_drained", drained, 0);
        chk("arst_stall_cnt", stall_cnt, 0);
        chk("arst_issue_cnt", issue_cnt, 0);
        model_reset();
        @(negedge clk1);
        rst_n = 1'b1;
        @(posedge clk1);
        model_edge(mk(1,1,1,2,1,4,1,0,0, 0,0,0,0,0));
        #1;
        chk("post_rst_issue", issue_cnt, 1);

        // Random traffic over a small register window to provoke hazards.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 400 == 399) do_reset();
            rv = mk($urandom_range(0,3) != 0, $urandom_range(0,7), $urandom_range(0,1),
                    $urandom_range(0,7), $urandom_range(0,1), $urandom_range(0,7),
                    $urandom_range(0,3) != 0, $urandom_range(0,149) == 0,
                    $urandom_range(0,7) == 0, 0,0,0,0,0);
            step(rv, 1'b0);
        end
        step(idle, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
